// File: rtl/pwm_pkg.sv
// Shared types and defaults for the time-shared PWM scheduler.
package pwm_pkg;

   // FSM state encoding for the scheduler
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_e;

   localparam int DUTY_W_DEF = 8;

   typedef logic [DUTY_W_DEF-1:0] duty_t;

endpackage : pwm_pkg

// File: rtl/pwm_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around. Returns one-hot winner, its index, and whether any won.
module pwm_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_idx,
   output logic               any
);

   int idx;

   // scan requesters starting at ptr, first hit wins
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      any        = 1'b0;
      idx        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[idx]) begin
            winner[idx] = 1'b1;
            winner_idx  = IDX_W'(idx);
            any         = 1'b1;
         end
      end
   end

endmodule : pwm_rr_arbiter

// File: rtl/pwm_share_scheduler.sv
// Time-shares one PWM generator among NUM_REQ requesters. Ownership only
// changes at period boundaries, so the output never glitches mid-period.
// Optional soft-start ramp is built when the macro PWM_RAMP_EN is defined.
//
//   state | meaning
//   IDLE  | no owner, counter parked at 0, pwm_out low
//   RUN   | owner holds generator, counter free-runs over the period
module pwm_share_scheduler
   import pwm_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DUTY_W       = DUTY_W_DEF,
   parameter int SLOT_PERIODS = 4,
   parameter int RAMP_STEP    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DUTY_W-1:0]  duty_in,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       pwm_out,
   output logic                       period_end,
   output logic                       busy
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SLOT_W = (SLOT_PERIODS > 1) ? $clog2(SLOT_PERIODS) : 1;
   localparam logic [DUTY_W-1:0] CNT_MAX   = '1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_PERIODS - 1);

   if (NUM_REQ < 2 || SLOT_PERIODS < 1 || RAMP_STEP < 0) begin : g_bad_param
      $error("pwm_share_scheduler: illegal parameter combination");
   end

   pwm_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [DUTY_W-1:0]   cnt_q, cnt_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic [DUTY_W-1:0]   duty_eff;
   logic                grant_change;
   logic                boundary;

   logic [IDX_W-1:0]    owner_inc;
   logic [IDX_W-1:0]    arb_ptr;
   logic [NUM_REQ-1:0]  win_onehot;
   logic [IDX_W-1:0]    win_idx;
   logic                win_any;
   logic [DUTY_W-1:0]   win_duty;
   logic [DUTY_W-1:0]   owner_duty;
   logic                others_pending;

   // In RUN the search starts just past the owner so a handover never
   // re-picks the current owner while anyone else is asking.
   assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign arb_ptr   = (state_q == RUN) ? owner_inc : rr_q;

   pwm_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req        (req),
      .ptr        (arb_ptr),
      .winner     (win_onehot),
      .winner_idx (win_idx),
      .any        (win_any)
   );

   assign win_duty       = duty_in[int'(win_idx)*DUTY_W +: DUTY_W];
   assign owner_duty     = duty_in[int'(owner_q)*DUTY_W +: DUTY_W];
   assign others_pending = |(req & ~grant_q);
   assign boundary       = (state_q == RUN) && (cnt_q == CNT_MAX);

   // next-state and datapath update; decisions only at period boundaries
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      rr_d         = rr_q;
      cnt_d        = cnt_q;
      slot_d       = slot_q;
      duty_d       = duty_q;
      grant_change = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               state_d      = RUN;
               grant_d      = win_onehot;
               owner_d      = win_idx;
               duty_d       = win_duty;
               cnt_d        = '0;
               slot_d       = '0;
               grant_change = 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
               if (!(|req)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end else if (!req[owner_q] || (slot_q == SLOT_LAST && others_pending)) begin
                  grant_d      = win_onehot;
                  owner_d      = win_idx;
                  rr_d         = owner_inc;
                  slot_d       = '0;
                  duty_d       = win_duty;
                  grant_change = 1'b1;
               end else begin
                  // sole or in-slot owner keeps going; slot count saturates
                  if (slot_q != SLOT_LAST) begin
                     slot_d = slot_q + 1'b1;
                  end
                  duty_d = owner_duty;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // scheduler registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         slot_q  <= '0;
         duty_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         duty_q  <= duty_d;
      end
   end

`ifdef PWM_RAMP_EN
   logic [DUTY_W-1:0] ramp_q, ramp_d;
   logic [DUTY_W:0]   ramp_sum;

   assign ramp_sum = {1'b0, ramp_q} + (DUTY_W+1)'(RAMP_STEP);

   // soft-start: restart from zero for every new owner, step up per period
   always_comb begin
      ramp_d = ramp_q;
      if (grant_change) begin
         ramp_d = '0;
      end else if (boundary) begin
         ramp_d = (ramp_sum > {1'b0, duty_d}) ? duty_d : ramp_sum[DUTY_W-1:0];
      end
   end

   // ramp register
   always_ff @(posedge clk) begin
      if (rst) begin
         ramp_q <= '0;
      end else begin
         ramp_q <= ramp_d;
      end
   end

   // a target lowered below the ramp takes effect immediately
   assign duty_eff = (ramp_q < duty_q) ? ramp_q : duty_q;
`else
   assign duty_eff = duty_q;
`endif

   assign grant      = grant_q;
   assign busy       = (state_q == RUN);
   assign period_end = busy && (cnt_q == CNT_MAX);
   assign pwm_out    = busy && (cnt_q < duty_eff);

endmodule : pwm_share_scheduler

// File: tb/tb_pwm_share_scheduler.sv
// Self-checking bench for pwm_share_scheduler: directed scenarios plus a
// randomized phase, all compared against a behavioural model of the rules.
// Build with PWM_RAMP_EN defined to exercise the soft-start ramp.
module tb_pwm_share_scheduler;

   localparam int N     = 4;
   localparam int DW    = 4;
   localparam int SLOT  = 2;
   localparam int STEP  = 4;
   localparam int PMAX  = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] duty_in;
   logic [N-1:0]    grant;
   logic            pwm_out;
   logic            period_end;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   int m_owner = -1;
   int m_cnt   = 0;
   int m_slot  = 0;
   int m_rr    = 0;
   int m_duty  = 0;
   int m_ramp  = 0;

   int acc_hi = 0;
   int acc_pe = 0;

   pwm_share_scheduler #(
      .NUM_REQ      (N),
      .DUTY_W       (DW),
      .SLOT_PERIODS (SLOT),
      .RAMP_STEP    (STEP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .duty_in    (duty_in),
      .grant      (grant),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int din(input int i);
      logic [DW-1:0] v;
      v = duty_in[i*DW +: DW];
      return int'(v);
   endfunction

   function automatic int rr_pick(input int start);
      for (int k = 0; k < N; k++) begin
         if (req[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic model_update();
      int  w;
      bit  other;
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_slot = 0; m_rr = 0; m_duty = 0; m_ramp = 0;
      end else if (m_owner < 0) begin
         if (req != '0) begin
            w = rr_pick(m_rr);
            m_owner = w; m_duty = din(w); m_cnt = 0; m_slot = 0; m_ramp = 0;
         end
      end else if (m_cnt == PMAX) begin
         m_cnt = 0;
         other = (req & ~(4'b0001 << m_owner)) != '0;
         if (req == '0) begin
            m_owner = -1;
         end else if (!req[m_owner] || (m_slot == SLOT - 1 && other)) begin
            w = rr_pick((m_owner + 1) % N);
            m_rr = (m_owner + 1) % N;
            m_owner = w; m_slot = 0; m_duty = din(w); m_ramp = 0;
         end else begin
            if (m_slot < SLOT - 1) m_slot++;
            m_duty = din(m_owner);
            m_ramp = (m_ramp + STEP > m_duty) ? m_duty : m_ramp + STEP;
         end
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_outputs();
      bit       e_busy;
      int       eff;
      logic [N-1:0] e_grant;
      e_busy  = (m_owner >= 0);
      e_grant = e_busy ? N'(1 << m_owner) : '0;
`ifdef PWM_RAMP_EN
      eff = (m_ramp < m_duty) ? m_ramp : m_duty;
`else
      eff = m_duty;
`endif
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant", 32'(grant), 32'(e_grant));
      chk("pwm_out", 32'(pwm_out), 32'(e_busy && (m_cnt < eff)));
      chk("period_end", 32'(period_end), 32'(e_busy && (m_cnt == PMAX)));
      acc_hi += int'(pwm_out === 1'b1);
      acc_pe += int'(period_end === 1'b1);
   endtask

   // one clock: check outputs mid-cycle, advance model on the edge
   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic align(input int target);
      for (int k = 0; k < 64 && m_cnt != target; k++) step();
      chk("align_cnt", 32'(m_cnt), 32'(target));
   endtask

   task automatic run_period(output int hi, output int pe);
      acc_hi = 0; acc_pe = 0;
      repeat (16) step();
      hi = acc_hi; pe = acc_pe;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin : main
      int hi, pe;
      logic [N-1:0] seq [$];
      int at [$];
      logic [N-1:0] exp_seq [4];
      int exp_ramp [5];

      rst = 1'b1; req = '0; duty_in = '0;
      @(posedge clk); #1;
      model_update();

      // reset / idle
      step(); step();
      rst = 1'b0;
      acc_pe = 0;
      repeat (20) step();
      chk("idle_no_period_end", 32'(acc_pe), 32'd0);

      // single owner, duty 5
      do_reset();
      duty_in[0 +: DW] = 4'd5;
      req = 4'b0001;
      step();
      chk("single_grant_latency", 32'(grant), 32'b0001);
      run_period(hi, pe);
`ifndef PWM_RAMP_EN
      chk("single_hi_p1", 32'(hi), 32'd5);
`endif
      chk("single_pe_p1", 32'(pe), 32'd1);
      run_period(hi, pe);
`ifndef PWM_RAMP_EN
      chk("single_hi_p2", 32'(hi), 32'd5);
`endif
      chk("single_grant_hold", 32'(grant), 32'b0001);

      // round robin over 1011
      do_reset();
      duty_in = {4'd12, 4'd9, 4'd7, 4'd3};
      req = 4'b1011;
      for (int k = 0; k < 200 && seq.size() < 4; k++) begin
         step();
         if (grant != '0 && (seq.size() == 0 || grant != seq[$])) begin
            seq.push_back(grant);
            at.push_back(k);
         end
      end
      exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      chk("rr_seq_len", 32'(seq.size()), 32'd4);
      for (int k = 0; k < 4 && k < seq.size(); k++) chk("rr_seq", 32'(seq[k]), 32'(exp_seq[k]));
      if (at.size() >= 2) chk("rr_hold_cycles", 32'(at[1] - at[0]), 32'd32);

      // early release, nobody else waiting
      do_reset();
      duty_in = '0;
      duty_in[0 +: DW] = 4'd12;
      req = 4'b0001;
      step();
      align(7);
      req = 4'b0000;
      align(PMAX);
      chk("release_busy_until_end", 32'(busy), 32'd1);
      step();
      chk("release_idle_busy", 32'(busy), 32'd0);
      chk("release_idle_grant", 32'(grant), 32'd0);

      // early release handing over
      do_reset();
      req = 4'b0101;
      step();
      align(7);
      req = 4'b0100;
      align(0);
      chk("release_handover", 32'(grant), 32'b0100);

      // duty extremes and mid-period change
`ifndef PWM_RAMP_EN
      do_reset();
      duty_in = '0;
      req = 4'b0001;
      step();
      run_period(hi, pe);
      chk("duty0_hi", 32'(hi), 32'd0);
      align(8);
      duty_in[0 +: DW] = 4'd15;
      align(0);
      run_period(hi, pe);
      chk("duty15_hi", 32'(hi), 32'd15);
      align(4);
      duty_in[0 +: DW] = 4'd3;
      acc_hi = 0;
      align(0);
      chk("mid_change_ignored", 32'(acc_hi), 32'd11);
      run_period(hi, pe);
      chk("mid_change_next", 32'(hi), 32'd3);
`endif

`ifdef PWM_RAMP_EN
      do_reset();
      duty_in = '0;
      duty_in[0 +: DW] = 4'd10;
      req = 4'b0001;
      step();
      exp_ramp = '{0, 4, 8, 10, 10};
      for (int k = 0; k < 5; k++) begin
         run_period(hi, pe);
         chk("ramp_hi", 32'(hi), 32'(exp_ramp[k]));
      end
`endif

      // reset in mid-period
      do_reset();
      duty_in[0 +: DW] = 4'd14;
      req = 4'b0001;
      step();
      align(9);
      rst = 1'b1;
      step();
      chk("midrst_pwm", 32'(pwm_out), 32'd0);
      chk("midrst_grant", 32'(grant), 32'd0);
      rst = 1'b0;

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(7) == 0) req = N'($urandom);
         if ($urandom_range(5) == 0) duty_in = (N*DW)'($urandom);
         rst = ($urandom_range(299) == 0);
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pwm_share_scheduler
